// File: rtl/uart_bridge_pio_pkg.sv
// Shared register map and edge-type encodings for the UART bridge PIO controller.
package uart_bridge_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/uart_bridge_pio_ctrl_if.sv
// Avalon-MM slave bus of the PIO controller: word address, active-low write, zero-wait read.
interface uart_bridge_pio_ctrl_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/uart_bridge_pio_edge.sv
// Two-flop input synchroniser plus previous-value register and per-bit edge detect.
// Latency: in_sync 2 clk edges after in_port; edge_pulse valid in the same cycle as the new in_sync.
// Backpressure: none, edge_pulse is a single-cycle strobe that must be consumed immediately.
module uart_bridge_pio_edge
    import uart_bridge_pio_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] in_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            in_prev <= '0;
        end else begin
            s1      <= in_port;
            s2      <= s1;
            in_prev <= s2;
        end
    end

    assign in_sync = s2;

    // Cleared in_prev means an input already high at reset release reads as one rising edge.
    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_pulse = ~s2 & in_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_pulse = s2 ^ in_prev;
        end else begin : g_rise
            assign edge_pulse = s2 & ~in_prev;
        end
    endgenerate

endmodule

// File: rtl/uart_bridge_pio_ctrl.sv
// General-purpose I/O slave: output data with set/clear, direction, edge capture, masked irq.
// Latency: writes land at the strobe edge; reads are combinational with zero wait states.
// Backpressure: none, the slave always accepts a write and never stalls a read.
module uart_bridge_pio_ctrl
    import uart_bridge_pio_pkg::*;
#(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '1,
    parameter int               EDGE_TYPE = EDGE_RISE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    uart_bridge_pio_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic [WIDTH-1:0]       out_port,
    output logic [WIDTH-1:0]       out_oe,
    output logic                   irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_dat;
    logic             wr;
    logic             unused_wdata;

    uart_bridge_pio_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir      <= DIR_RESET;
            irqmask  <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:    data_out <= wdata;
                ADDR_DIR:     dir      <= wdata;
                ADDR_IRQMASK: irqmask  <= wdata;
                ADDR_OUTSET:  data_out <= data_out | wdata;
                ADDR_OUTCLR:  data_out <= data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    assign cap_clr = (wr && bus.address == ADDR_EDGECAP) ? wdata : '0;

    // A new edge is OR-ed in after the clear so it survives a same-cycle write-1-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_pulse;
        end
    end

    always_comb begin
        rd_dat = '0;
        case (bus.address)
            ADDR_DATA:    rd_dat[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
            ADDR_DIR:     rd_dat[WIDTH-1:0] = dir;
            ADDR_IRQMASK: rd_dat[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_dat[WIDTH-1:0] = edgecap;
            default:      rd_dat = '0;
        endcase
    end

    assign bus.readdata = rd_dat;
    assign out_port     = data_out;
    assign out_oe       = dir;
    assign irq          = |(edgecap & irqmask);

endmodule
